// File: rtl/ex_operand_reg.sv
// ex_operand_reg: ID->EX pipeline register with operand forwarding and hazard detection.
//
// The register captures the decoded ID fields on each enabled clock edge. It refreshes
// the stored rs/rt data from the WB stage while the pipeline is held. It builds the ALU
// operands from the stored (or forwarded) register values and flags load-use and
// data-dependence stalls back to ID.
//
// Configuration macro: EX_FORWARD_EN
//   defined   - combinational MEM/WB forwarding into EX; ID stalls only on load-use.
//   undefined - EX uses stored data only; ID also stalls on any EX/MEM destination match.
//
// Ports:
//   clk, rst                      clock (rising edge), asynchronous active-high reset
//   en, flush                     pipeline advance (0 = hold), kill the ID->EX transfer
//   id_*                          decoded instruction fields from ID
//   mem_wb_*, wb_wb_*             MEM- and WB-stage register writes
//   ex_valid                      EX holds a real instruction
//   alu_a, alu_b, alu_oper,
//   alu_sign                      ALU operands and control
//   ex_store_data                 forwarded rt value for stores
//   ex_wb_en, ex_wb_addr,
//   ex_mem_read                   EX destination and load flag
//   hazard_stall                  combinational request for ID to hold

module ex_operand_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        flush,
    input  logic        id_valid,
    input  logic [4:0]  id_rs_addr,
    input  logic [4:0]  id_rt_addr,
    input  logic [31:0] id_rs_data,
    input  logic [31:0] id_rt_data,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_shamt,
    input  logic [1:0]  id_a_sel,
    input  logic        id_b_sel,
    input  logic [3:0]  id_oper,
    input  logic        id_sign,
    input  logic        id_wb_en,
    input  logic [4:0]  id_wb_addr,
    input  logic        id_mem_read,
    input  logic        mem_wb_en,
    input  logic [4:0]  mem_wb_addr,
    input  logic [31:0] mem_wb_data,
    input  logic        wb_wb_en,
    input  logic [4:0]  wb_wb_addr,
    input  logic [31:0] wb_wb_data,
    output logic        ex_valid,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_oper,
    output logic        alu_sign,
    output logic [31:0] ex_store_data,
    output logic        ex_wb_en,
    output logic [4:0]  ex_wb_addr,
    output logic        ex_mem_read,
    output logic        hazard_stall
);

    logic        valid_q;
    logic [4:0]  rs_addr_q;
    logic [4:0]  rt_addr_q;
    logic [31:0] rs_data_q;
    logic [31:0] rt_data_q;
    logic [31:0] imm_q;
    logic [4:0]  shamt_q;
    logic [1:0]  a_sel_q;
    logic        b_sel_q;
    logic [3:0]  oper_q;
    logic        sign_q;
    logic        wb_en_q;
    logic [4:0]  wb_addr_q;
    logic        mem_read_q;

    logic        cap_rs_hit;
    logic        cap_rt_hit;
    logic        hold_rs_hit;
    logic        hold_rt_hit;
    logic        take;
    logic        ex_dep;
    logic        load_use;
    logic [31:0] rs_fwd;
    logic [31:0] rt_fwd;

    // WB write matches: at capture against the ID sources, while held against the stored ones.
    always_comb begin
        cap_rs_hit  = wb_wb_en && (wb_wb_addr != 5'd0) && (wb_wb_addr == id_rs_addr);
        cap_rt_hit  = wb_wb_en && (wb_wb_addr != 5'd0) && (wb_wb_addr == id_rt_addr);
        hold_rs_hit = wb_wb_en && (wb_wb_addr != 5'd0) && (wb_wb_addr == rs_addr_q);
        hold_rt_hit = wb_wb_en && (wb_wb_addr != 5'd0) && (wb_wb_addr == rt_addr_q);
    end

    // ID source matches the instruction currently in EX.
    always_comb begin
        ex_dep   = wb_en_q && (wb_addr_q != 5'd0) &&
                   ((wb_addr_q == id_rs_addr) || (wb_addr_q == id_rt_addr));
        load_use = id_valid && valid_q && mem_read_q && ex_dep;
    end

`ifdef EX_FORWARD_EN
    always_comb begin
        hazard_stall = load_use;

        rs_fwd = rs_data_q;
        if (mem_wb_en && (mem_wb_addr != 5'd0) && (mem_wb_addr == rs_addr_q)) begin
            rs_fwd = mem_wb_data;
        end else if (hold_rs_hit) begin
            rs_fwd = wb_wb_data;
        end

        rt_fwd = rt_data_q;
        if (mem_wb_en && (mem_wb_addr != 5'd0) && (mem_wb_addr == rt_addr_q)) begin
            rt_fwd = mem_wb_data;
        end else if (hold_rt_hit) begin
            rt_fwd = wb_wb_data;
        end
    end
`else
    logic mem_dep;
    logic unused_mem_data;

    assign unused_mem_data = ^mem_wb_data;

    // Without forwarding, ID waits until every older producer has reached WB.
    always_comb begin
        mem_dep      = mem_wb_en && (mem_wb_addr != 5'd0) &&
                       ((mem_wb_addr == id_rs_addr) || (mem_wb_addr == id_rt_addr));
        hazard_stall = load_use || (id_valid && ((valid_q && ex_dep) || mem_dep));
        rs_fwd       = rs_data_q;
        rt_fwd       = rt_data_q;
    end
`endif

    // flush and stall both turn the capture into a bubble; flush wins by construction.
    assign take = id_valid && !flush && !hazard_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q    <= 1'b0;
            rs_addr_q  <= 5'd0;
            rt_addr_q  <= 5'd0;
            rs_data_q  <= 32'd0;
            rt_data_q  <= 32'd0;
            imm_q      <= 32'd0;
            shamt_q    <= 5'd0;
            a_sel_q    <= 2'd0;
            b_sel_q    <= 1'b0;
            oper_q     <= 4'h0;
            sign_q     <= 1'b0;
            wb_en_q    <= 1'b0;
            wb_addr_q  <= 5'd0;
            mem_read_q <= 1'b0;
        end else if (en) begin
            valid_q    <= take;
            rs_addr_q  <= id_rs_addr;
            rt_addr_q  <= id_rt_addr;
            rs_data_q  <= cap_rs_hit ? wb_wb_data : id_rs_data;
            rt_data_q  <= cap_rt_hit ? wb_wb_data : id_rt_data;
            imm_q      <= id_imm;
            shamt_q    <= id_shamt;
            a_sel_q    <= id_a_sel;
            b_sel_q    <= id_b_sel;
            oper_q     <= id_oper;
            sign_q     <= id_sign;
            wb_en_q    <= take && id_wb_en;
            wb_addr_q  <= id_wb_addr;
            mem_read_q <= take && id_mem_read;
        end else if (valid_q) begin
            // A value retiring from WB during a hold would otherwise never reach EX.
            if (hold_rs_hit) rs_data_q <= wb_wb_data;
            if (hold_rt_hit) rt_data_q <= wb_wb_data;
        end
    end

    always_comb begin
        unique case (a_sel_q)
            2'd0:    alu_a = rs_fwd;
            2'd1:    alu_a = {27'd0, shamt_q};
            2'd2:    alu_a = 32'd16;
            default: alu_a = 32'd0;
        endcase
        alu_b = b_sel_q ? imm_q : rt_fwd;
    end

    assign ex_store_data = rt_fwd;
    assign ex_valid      = valid_q;
    assign alu_oper      = oper_q;
    assign alu_sign      = sign_q;
    assign ex_wb_en      = wb_en_q;
    assign ex_wb_addr    = wb_addr_q;
    assign ex_mem_read   = mem_read_q;

endmodule

// File: tb/tb_ex_operand_reg.sv
// Testbench for ex_operand_reg: directed scenarios plus randomized traffic checked
// against a behavioural model of what the EX stage should contain.

module tb_ex_operand_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        en, flush, id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_shamt, id_wb_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm;
    logic [1:0]  id_a_sel;
    logic        id_b_sel, id_sign, id_wb_en, id_mem_read;
    logic [3:0]  id_oper;
    logic        mem_wb_en, wb_wb_en;
    logic [4:0]  mem_wb_addr, wb_wb_addr;
    logic [31:0] mem_wb_data, wb_wb_data;
    logic        ex_valid, alu_sign, ex_wb_en, ex_mem_read, hazard_stall;
    logic [31:0] alu_a, alu_b, ex_store_data;
    logic [3:0]  alu_oper;
    logic [4:0]  ex_wb_addr;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    ex_operand_reg dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
        .id_imm(id_imm), .id_shamt(id_shamt), .id_a_sel(id_a_sel), .id_b_sel(id_b_sel),
        .id_oper(id_oper), .id_sign(id_sign), .id_wb_en(id_wb_en), .id_wb_addr(id_wb_addr),
        .id_mem_read(id_mem_read),
        .mem_wb_en(mem_wb_en), .mem_wb_addr(mem_wb_addr), .mem_wb_data(mem_wb_data),
        .wb_wb_en(wb_wb_en), .wb_wb_addr(wb_wb_addr), .wb_wb_data(wb_wb_data),
        .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b), .alu_oper(alu_oper),
        .alu_sign(alu_sign), .ex_store_data(ex_store_data), .ex_wb_en(ex_wb_en),
        .ex_wb_addr(ex_wb_addr), .ex_mem_read(ex_mem_read), .hazard_stall(hazard_stall)
    );

    // Model of the instruction sitting in EX.
    logic        m_valid, m_wb_en, m_mem_read, m_b_sel, m_sign;
    logic [1:0]  m_a_sel;
    logic [3:0]  m_oper;
    logic [4:0]  m_rs_addr, m_rt_addr, m_wb_addr, m_shamt;
    logic [31:0] m_rs, m_rt, m_imm;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Does a register write (we, wa) produce architectural register r?
    function automatic logic writes(input logic we, input logic [4:0] wa, input logic [4:0] r);
        return we && (wa != 5'd0) && (wa == r);
    endfunction

    // Current architectural value of source r as EX should see it.
    function automatic logic [31:0] src_value(input logic [4:0] r, input logic [31:0] stored);
`ifdef EX_FORWARD_EN
        if (writes(mem_wb_en, mem_wb_addr, r)) return mem_wb_data;
        if (writes(wb_wb_en, wb_wb_addr, r)) return wb_wb_data;
`endif
        return stored;
    endfunction

    function automatic logic exp_stall();
        logic dep_ex;
        dep_ex = writes(m_wb_en, m_wb_addr, id_rs_addr) || writes(m_wb_en, m_wb_addr, id_rt_addr);
`ifdef EX_FORWARD_EN
        return id_valid && m_valid && m_mem_read && dep_ex;
`else
        return id_valid && ((m_valid && dep_ex) ||
                            writes(mem_wb_en, mem_wb_addr, id_rs_addr) ||
                            writes(mem_wb_en, mem_wb_addr, id_rt_addr));
`endif
    endfunction

    task automatic model_clear();
        m_valid = 0; m_wb_en = 0; m_mem_read = 0; m_b_sel = 0; m_sign = 0; m_a_sel = 0;
        m_oper = 0; m_rs_addr = 0; m_rt_addr = 0; m_wb_addr = 0; m_shamt = 0;
        m_rs = 0; m_rt = 0; m_imm = 0;
    endtask

    task automatic check_outputs();
        logic [31:0] a_opts [4];
        logic [31:0] rt_val;
        a_opts[0] = src_value(m_rs_addr, m_rs);
        a_opts[1] = {27'd0, m_shamt};
        a_opts[2] = 32'd16;
        a_opts[3] = 32'd0;
        rt_val    = src_value(m_rt_addr, m_rt);
        check_eq("ex_valid", {31'd0, ex_valid}, {31'd0, m_valid});
        check_eq("alu_a", alu_a, a_opts[m_a_sel]);
        check_eq("alu_b", alu_b, m_b_sel ? m_imm : rt_val);
        check_eq("store_data", ex_store_data, rt_val);
        check_eq("alu_oper", {28'd0, alu_oper}, {28'd0, m_oper});
        check_eq("alu_sign", {31'd0, alu_sign}, {31'd0, m_sign});
        check_eq("ex_wb_en", {31'd0, ex_wb_en}, {31'd0, m_wb_en});
        check_eq("ex_wb_addr", {27'd0, ex_wb_addr}, {27'd0, m_wb_addr});
        check_eq("ex_mem_read", {31'd0, ex_mem_read}, {31'd0, m_mem_read});
        check_eq("hazard_stall", {31'd0, hazard_stall}, {31'd0, exp_stall()});
    endtask

    task automatic model_update();
        logic keep;
        if (en) begin
            keep       = id_valid && !flush && !exp_stall();
            m_valid    = keep;
            m_wb_en    = keep && id_wb_en;
            m_mem_read = keep && id_mem_read;
            m_rs       = writes(wb_wb_en, wb_wb_addr, id_rs_addr) ? wb_wb_data : id_rs_data;
            m_rt       = writes(wb_wb_en, wb_wb_addr, id_rt_addr) ? wb_wb_data : id_rt_data;
            m_rs_addr  = id_rs_addr; m_rt_addr = id_rt_addr; m_wb_addr = id_wb_addr;
            m_imm      = id_imm; m_shamt = id_shamt; m_a_sel = id_a_sel; m_b_sel = id_b_sel;
            m_oper     = id_oper; m_sign = id_sign;
        end else if (m_valid) begin
            if (writes(wb_wb_en, wb_wb_addr, m_rs_addr)) m_rs = wb_wb_data;
            if (writes(wb_wb_en, wb_wb_addr, m_rt_addr)) m_rt = wb_wb_data;
        end
    endtask

    // Inputs are set just after a rising edge; check mid-cycle, then cross the next edge.
    task automatic step();
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet_inputs();
        en = 1; flush = 0; id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_data = 0;
        id_rt_data = 0; id_imm = 0; id_shamt = 0; id_a_sel = 0; id_b_sel = 0; id_oper = 0;
        id_sign = 0; id_wb_en = 0; id_wb_addr = 0; id_mem_read = 0;
        mem_wb_en = 0; mem_wb_addr = 0; mem_wb_data = 0;
        wb_wb_en = 0; wb_wb_addr = 0; wb_wb_data = 0;
    endtask

    task automatic random_inputs();
        en          = ($urandom_range(9) < 8);
        flush       = ($urandom_range(9) == 0);
        id_valid    = ($urandom_range(9) < 8);
        id_rs_addr  = 5'($urandom_range(3));
        id_rt_addr  = 5'($urandom_range(3));
        id_rs_data  = $urandom;
        id_rt_data  = $urandom;
        id_imm      = $urandom;
        id_shamt    = 5'($urandom);
        id_a_sel    = 2'($urandom);
        id_b_sel    = 1'($urandom);
        id_oper     = 4'($urandom);
        id_sign     = 1'($urandom);
        id_wb_en    = 1'($urandom);
        id_wb_addr  = 5'($urandom_range(3));
        id_mem_read = ($urandom_range(9) < 3);
        mem_wb_en   = 1'($urandom);
        mem_wb_addr = 5'($urandom_range(3));
        mem_wb_data = $urandom;
        wb_wb_en    = 1'($urandom);
        wb_wb_addr  = 5'($urandom_range(3));
        wb_wb_data  = $urandom;
    endtask

    // Asynchronous reset in the middle of a held/flushed cycle.
    task automatic reset_mid_cycle();
        en = 0; flush = 1; mem_wb_en = 0; wb_wb_en = 0;
        #3 rst = 1;
        #1;
        check_eq("rst_ex_valid", {31'd0, ex_valid}, 32'd0);
        check_eq("rst_alu_a", alu_a, 32'd0);
        check_eq("rst_alu_b", alu_b, 32'd0);
        check_eq("rst_store", ex_store_data, 32'd0);
        check_eq("rst_ctrl", {22'd0, alu_oper, alu_sign, ex_wb_en, ex_wb_addr, ex_mem_read},
                 32'd0);
        check_eq("rst_stall", {31'd0, hazard_stall}, 32'd0);
        model_clear();
        @(posedge clk);
        #2 rst = 0;
        quiet_inputs();
    endtask

    initial begin
        rst = 1;
        quiet_inputs();
        model_clear();
        #12;
        check_outputs();
        @(posedge clk);
        #2 rst = 0;

        // Operand select paths.
        id_valid = 1; id_a_sel = 1; id_shamt = 5'd31; id_b_sel = 1; id_imm = 32'hFFFF8000;
        step();
        check_eq("shamt_a", alu_a, 32'h0000001F);
        check_eq("imm_b", alu_b, 32'hFFFF8000);
        id_a_sel = 2;
        step();
        check_eq("const16_a", alu_a, 32'h00000010);

        // Stored rs refreshed by a WB write during a three-cycle hold.
        id_a_sel = 0; id_b_sel = 0; id_rs_addr = 7; id_rs_data = 32'h1; id_wb_en = 1;
        id_wb_addr = 9;
        step();
        en = 0;
        step();
        wb_wb_en = 1; wb_wb_addr = 7; wb_wb_data = 32'hABCD;
        step();
        wb_wb_en = 0;
        step();
        check_eq("hold_refresh", alu_a, 32'h0000ABCD);

        // Load in EX, dependent in ID with flush: bubble.
        en = 1; id_rs_addr = 0; id_rt_addr = 0; id_mem_read = 1; id_wb_en = 1; id_wb_addr = 5;
        step();
        id_mem_read = 0; id_wb_en = 0; id_rt_addr = 5; flush = 1;
        #1;
        check_eq("load_use", {31'd0, hazard_stall}, 32'd1);
        step();
        check_eq("flush_bubble", {31'd0, ex_valid}, 32'd0);

        // Writes to $0 never forward.
        flush = 0; id_rt_addr = 0; id_rs_data = 32'h99;
        step();
        mem_wb_en = 1; mem_wb_addr = 0; mem_wb_data = 32'h5;
        #1;
        check_eq("r0_no_fwd", alu_a, 32'h99);
        step();

        for (int i = 0; i < 400; i++) begin
            if (i == 200) reset_mid_cycle();
            else random_inputs();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
